// File: rtl/banco_registro_param_if.sv
// -----------------------------------------------------------------------------
// banco_registro_param_if
// Bus bundle between the decode stage / ALU operand latches and the register
// bank.
//   master : drives write port, read addresses/enable and soft-clear request
//   slave  : the register bank; returns registered read data and clear status
// Signals:
//   wr_en, wr_addr, wr_data        write port
//   rd_en, rd_a_addr, rd_b_addr    read request (both ports update on rd_en)
//   rd_a_data, rd_b_data           registered read data
//   clr_req                        soft-clear request
//   clr_busy, clr_done             soft-clear status (busy level, done pulse)
// -----------------------------------------------------------------------------
interface banco_registro_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_a_addr;
   logic [ADDR_W-1:0] rd_b_addr;
   logic [DATA_W-1:0] rd_a_data;
   logic [DATA_W-1:0] rd_b_data;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;

   modport master (
      output wr_en, wr_addr, wr_data,
      output rd_en, rd_a_addr, rd_b_addr,
      output clr_req,
      input  rd_a_data, rd_b_data,
      input  clr_busy, clr_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  rd_en, rd_a_addr, rd_b_addr,
      input  clr_req,
      output rd_a_data, rd_b_data,
      output clr_busy, clr_done
   );
endinterface

// File: rtl/banco_registro_param.sv
// -----------------------------------------------------------------------------
// banco_registro_param
// Parametrised register bank: NUM_REGS words of DATA_W bits, one write port,
// two independent registered read ports, optional write-to-read bypass,
// optional hardwired-zero register 0 and a sequenced soft-clear engine that
// wipes one word per cycle.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    banco_registro_param_if.slave (write/read/clear signals)
//
// Soft-clear FSM:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | normal operation, writes accepted, clr_req sampled
//   ST_CLEAR | one word zeroed per edge at clr_idx_q, writes dropped
//   ST_DONE  | single cycle, clr_done high, writes dropped, then ST_IDLE
// -----------------------------------------------------------------------------
module banco_registro_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int NUM_REGS = 8,
   parameter int ZERO_R0  = 0,
   parameter int BYPASS   = 1
) (
   input logic                   clock,
   input logic                   reset,
   banco_registro_param_if.slave bus
);

   localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic              clr_busy_q, clr_busy_d;
   logic              clr_done_q, clr_done_d;
   logic [DATA_W-1:0] rd_a_q, rd_a_d;
   logic [DATA_W-1:0] rd_b_q, rd_b_d;
   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] mem_d [NUM_REGS];
   logic              wr_ok;

   // An address names a real, writable/readable word: in range and not the
   // hardwired-zero register.
   function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
      logic in_range;
      logic is_r0;
      in_range = ({1'b0, addr} < NUM_REGS_X);
      is_r0    = (ZERO_R0 != 0) && (addr == '0);
      return in_range && !is_r0;
   endfunction

   // Writes only land while idle; the clear engine owns the array otherwise.
   assign wr_ok = bus.wr_en && (state_q == ST_IDLE) && addr_valid(bus.wr_addr);

   always_comb begin
      state_d    = state_q;
      clr_idx_d  = clr_idx_q;
      clr_busy_d = 1'b0;
      clr_done_d = 1'b0;
      mem_d      = mem_q;
      rd_a_d     = rd_a_q;
      rd_b_d     = rd_b_q;

      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
            mem_d[i] = bus.wr_data;
         end
      end

      case (state_q)
         ST_IDLE: begin
            // A write accepted on this same edge is still taken; the clear
            // then wipes it later, since every index is visited.
            if (bus.clr_req) begin
               state_d    = ST_CLEAR;
               clr_idx_d  = '0;
               clr_busy_d = 1'b1;
            end
         end
         ST_CLEAR: begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (clr_idx_q == ADDR_W'(i)) begin
                  mem_d[i] = '0;
               end
            end
            if (clr_idx_q == LAST_IDX) begin
               state_d    = ST_DONE;
               clr_done_d = 1'b1;
            end else begin
               clr_idx_d  = clr_idx_q + 1'b1;
               clr_busy_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Read ports sample the pre-edge array; the bypass substitutes the
      // incoming write data so the result looks write-first.
      if (bus.rd_en) begin
         rd_a_d = '0;
         if (addr_valid(bus.rd_a_addr)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (bus.rd_a_addr == ADDR_W'(i)) begin
                  rd_a_d = mem_q[i];
               end
            end
            if ((BYPASS != 0) && wr_ok && (bus.rd_a_addr == bus.wr_addr)) begin
               rd_a_d = bus.wr_data;
            end
         end

         rd_b_d = '0;
         if (addr_valid(bus.rd_b_addr)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (bus.rd_b_addr == ADDR_W'(i)) begin
                  rd_b_d = mem_q[i];
               end
            end
            if ((BYPASS != 0) && wr_ok && (bus.rd_b_addr == bus.wr_addr)) begin
               rd_b_d = bus.wr_data;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         clr_idx_q  <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
         rd_a_q     <= '0;
         rd_b_q     <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         clr_busy_q <= clr_busy_d;
         clr_done_q <= clr_done_d;
         rd_a_q     <= rd_a_d;
         rd_b_q     <= rd_b_d;
         mem_q      <= mem_d;
      end
   end

   assign bus.rd_a_data = rd_a_q;
   assign bus.rd_b_data = rd_b_q;
   assign bus.clr_busy  = clr_busy_q;
   assign bus.clr_done  = clr_done_q;

endmodule

// File: tb/tb_banco_registro_param.sv
// -----------------------------------------------------------------------------
// tb_banco_registro_param
// Three bank instances share one stimulus stream:
//   u_def : defaults (8 regs, bypass on, no zero register)
//   u_rf  : bypass off (read-first)
//   u_z   : 6 regs, register 0 hardwired to zero, bypass on
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_banco_registro_param;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        rd_en = 1'b0;
   logic [2:0]  rd_a_addr = '0;
   logic [2:0]  rd_b_addr = '0;
   logic        clr_req = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   banco_registro_param_if #(.DATA_W(16), .ADDR_W(3)) bus_def ();
   banco_registro_param_if #(.DATA_W(16), .ADDR_W(3)) bus_rf ();
   banco_registro_param_if #(.DATA_W(16), .ADDR_W(3)) bus_z ();

   assign bus_def.wr_en     = wr_en;
   assign bus_def.wr_addr   = wr_addr;
   assign bus_def.wr_data   = wr_data;
   assign bus_def.rd_en     = rd_en;
   assign bus_def.rd_a_addr = rd_a_addr;
   assign bus_def.rd_b_addr = rd_b_addr;
   assign bus_def.clr_req   = clr_req;

   assign bus_rf.wr_en      = wr_en;
   assign bus_rf.wr_addr    = wr_addr;
   assign bus_rf.wr_data    = wr_data;
   assign bus_rf.rd_en      = rd_en;
   assign bus_rf.rd_a_addr  = rd_a_addr;
   assign bus_rf.rd_b_addr  = rd_b_addr;
   assign bus_rf.clr_req    = clr_req;

   assign bus_z.wr_en       = wr_en;
   assign bus_z.wr_addr     = wr_addr;
   assign bus_z.wr_data     = wr_data;
   assign bus_z.rd_en       = rd_en;
   assign bus_z.rd_a_addr   = rd_a_addr;
   assign bus_z.rd_b_addr   = rd_b_addr;
   assign bus_z.clr_req     = clr_req;

   banco_registro_param #(
      .DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .ZERO_R0(0), .BYPASS(1)
   ) u_def (
      .clock (clock),
      .reset (reset),
      .bus   (bus_def)
   );

   banco_registro_param #(
      .DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .ZERO_R0(0), .BYPASS(0)
   ) u_rf (
      .clock (clock),
      .reset (reset),
      .bus   (bus_rf)
   );

   banco_registro_param #(
      .DATA_W(16), .ADDR_W(3), .NUM_REGS(6), .ZERO_R0(1), .BYPASS(1)
   ) u_z (
      .clock (clock),
      .reset (reset),
      .bus   (bus_z)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_a: got %h want 0000", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_b: got %h want 0000", bus_def.rd_b_data); end
      total++; if (bus_def.clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_def.clr_busy); end
      total++; if (bus_def.clr_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus_def.clr_done); end
      reset = 1'b1;
      tick();
      rd_en = 1'b1; rd_a_addr = 3'd3; rd_b_addr = 3'd5;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL reset_array_a: got %h want 0000", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'h0000) begin bad++; $display("FAIL reset_array_b: got %h want 0000", bus_def.rd_b_data); end
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
      tick();
      wr_addr = 3'd5; wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1; rd_a_addr = 3'd3; rd_b_addr = 3'd5;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h1234) begin bad++; $display("FAIL wr_rd_a: got %h want 1234", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_b: got %h want beef", bus_def.rd_b_data); end
      total++; if (bus_rf.rd_a_data !== 16'h1234) begin bad++; $display("FAIL wr_rd_rf_a: got %h want 1234", bus_rf.rd_a_data); end
      total++; if (bus_z.rd_b_data !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_z_b: got %h want beef", bus_z.rd_b_data); end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1111;
      tick();
      wr_data = 16'hA5A5;
      rd_en = 1'b1; rd_a_addr = 3'd2; rd_b_addr = 3'd2;
      tick();
      wr_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'hA5A5) begin bad++; $display("FAIL byp_def_a: got %h want a5a5", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'hA5A5) begin bad++; $display("FAIL byp_def_b: got %h want a5a5", bus_def.rd_b_data); end
      total++; if (bus_rf.rd_a_data !== 16'h1111) begin bad++; $display("FAIL byp_rf_a: got %h want 1111", bus_rf.rd_a_data); end
      total++; if (bus_rf.rd_b_data !== 16'h1111) begin bad++; $display("FAIL byp_rf_b: got %h want 1111", bus_rf.rd_b_data); end
      total++; if (bus_z.rd_a_data !== 16'hA5A5) begin bad++; $display("FAIL byp_z_a: got %h want a5a5", bus_z.rd_a_data); end
      rd_a_addr = 3'd2; rd_b_addr = 3'd3;
      tick();
      rd_en = 1'b0;
      total++; if (bus_rf.rd_a_data !== 16'hA5A5) begin bad++; $display("FAIL byp_rf_next_a: got %h want a5a5", bus_rf.rd_a_data); end
      total++; if (bus_rf.rd_b_data !== 16'h1234) begin bad++; $display("FAIL byp_rf_next_b: got %h want 1234", bus_rf.rd_b_data); end
   endtask

   task automatic test_zero_oor();
      logic [15:0] exp_z [8];
      exp_z = '{16'h0000, 16'h0000, 16'hA5A5, 16'h1234,
                16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
      rd_en = 1'b1; rd_a_addr = 3'd0; rd_b_addr = 3'd3;
      tick();
      wr_en = 1'b0;
      total++; if (bus_z.rd_a_data !== 16'h0000) begin bad++; $display("FAIL z_r0_byp: got %h want 0000", bus_z.rd_a_data); end
      total++; if (bus_z.rd_b_data !== 16'h1234) begin bad++; $display("FAIL z_r3: got %h want 1234", bus_z.rd_b_data); end
      total++; if (bus_def.rd_a_data !== 16'hFFFF) begin bad++; $display("FAIL def_r0_byp: got %h want ffff", bus_def.rd_a_data); end
      total++; if (bus_rf.rd_a_data !== 16'h0000) begin bad++; $display("FAIL rf_r0_old: got %h want 0000", bus_rf.rd_a_data); end
      tick();
      total++; if (bus_z.rd_a_data !== 16'h0000) begin bad++; $display("FAIL z_r0_read: got %h want 0000", bus_z.rd_a_data); end
      total++; if (bus_rf.rd_a_data !== 16'hFFFF) begin bad++; $display("FAIL rf_r0_read: got %h want ffff", bus_rf.rd_a_data); end
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
      rd_a_addr = 3'd7; rd_b_addr = 3'd5;
      tick();
      wr_en = 1'b0;
      total++; if (bus_z.rd_a_data !== 16'h0000) begin bad++; $display("FAIL z_oor_byp: got %h want 0000", bus_z.rd_a_data); end
      total++; if (bus_z.rd_b_data !== 16'hBEEF) begin bad++; $display("FAIL z_r5_oor_wr: got %h want beef", bus_z.rd_b_data); end
      total++; if (bus_def.rd_a_data !== 16'h7777) begin bad++; $display("FAIL def_r7_byp: got %h want 7777", bus_def.rd_a_data); end
      total++; if (bus_rf.rd_a_data !== 16'h0000) begin bad++; $display("FAIL rf_r7_old: got %h want 0000", bus_rf.rd_a_data); end
      for (int i = 0; i < 4; i++) begin
         rd_a_addr = 3'(2*i); rd_b_addr = 3'(2*i + 1);
         tick();
         total++; if (bus_z.rd_a_data !== exp_z[2*i]) begin bad++; $display("FAIL z_scan_r%0d: got %h want %h", 2*i, bus_z.rd_a_data, exp_z[2*i]); end
         total++; if (bus_z.rd_b_data !== exp_z[2*i+1]) begin bad++; $display("FAIL z_scan_r%0d: got %h want %h", 2*i+1, bus_z.rd_b_data, exp_z[2*i+1]); end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_hold();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
      tick();
      wr_addr = 3'd3; wr_data = 16'h3333;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1; rd_a_addr = 3'd2; rd_b_addr = 3'd3;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h2222) begin bad++; $display("FAIL hold_load_a: got %h want 2222", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'h3333) begin bad++; $display("FAIL hold_load_b: got %h want 3333", bus_def.rd_b_data); end
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = 3'(i + 2); wr_data = 16'h9000 | 16'(i);
         rd_a_addr = 3'(i); rd_b_addr = 3'(7 - i);
         tick();
         total++; if (bus_def.rd_a_data !== 16'h2222) begin bad++; $display("FAIL hold_a_%0d: got %h want 2222", i, bus_def.rd_a_data); end
         total++; if (bus_def.rd_b_data !== 16'h3333) begin bad++; $display("FAIL hold_b_%0d: got %h want 3333", i, bus_def.rd_b_data); end
      end
      wr_en = 1'b0;
      rd_en = 1'b1; rd_a_addr = 3'd2; rd_b_addr = 3'd3;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h9000) begin bad++; $display("FAIL hold_after_a: got %h want 9000", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'h9001) begin bad++; $display("FAIL hold_after_b: got %h want 9001", bus_def.rd_b_data); end
   endtask

   task automatic test_clear();
      int busy_cycles;
      wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_addr = 3'(i); wr_data = 16'(17 * (i + 1));
         tick();
      end
      wr_en = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_cycles = 0;
      if (bus_def.clr_busy === 1'b1) busy_cycles++;
      total++; if (bus_def.clr_done !== 1'b0) begin bad++; $display("FAIL clr_start_done: got %b want 0", bus_def.clr_done); end
      for (int k = 1; k <= 9; k++) begin
         wr_en = (k == 2); wr_addr = 3'd7; wr_data = 16'hDEAD;
         rd_en = (k == 4) || (k == 5);
         rd_a_addr = 3'd3; rd_b_addr = (k == 4) ? 3'd4 : 3'd7;
         tick();
         if (bus_def.clr_busy === 1'b1) busy_cycles++;
         if (k == 4) begin
            total++; if (bus_def.rd_a_data !== 16'h0044) begin bad++; $display("FAIL clr_e4_r3: got %h want 0044", bus_def.rd_a_data); end
            total++; if (bus_def.rd_b_data !== 16'h0055) begin bad++; $display("FAIL clr_e4_r4: got %h want 0055", bus_def.rd_b_data); end
            total++; if (bus_z.rd_a_data !== 16'h0044) begin bad++; $display("FAIL clr_z_e4_r3: got %h want 0044", bus_z.rd_a_data); end
         end
         if (k == 5) begin
            total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL clr_e5_r3: got %h want 0000", bus_def.rd_a_data); end
            total++; if (bus_def.rd_b_data !== 16'h0088) begin bad++; $display("FAIL clr_e5_r7: got %h want 0088", bus_def.rd_b_data); end
            total++; if (bus_z.rd_a_data !== 16'h0000) begin bad++; $display("FAIL clr_z_e5_r3: got %h want 0000", bus_z.rd_a_data); end
         end
         if (k == 6) begin
            total++; if (bus_z.clr_done !== 1'b1) begin bad++; $display("FAIL clr_z_done: got %b want 1", bus_z.clr_done); end
         end
         if (k == 8) begin
            total++; if (bus_def.clr_done !== 1'b1) begin bad++; $display("FAIL clr_done_pulse: got %b want 1", bus_def.clr_done); end
            total++; if (bus_def.clr_busy !== 1'b0) begin bad++; $display("FAIL clr_done_busy: got %b want 0", bus_def.clr_busy); end
         end
         if (k == 9) begin
            total++; if (bus_def.clr_done !== 1'b0) begin bad++; $display("FAIL clr_done_width: got %b want 0", bus_def.clr_done); end
         end
      end
      wr_en = 1'b0;
      total++; if (busy_cycles !== 8) begin bad++; $display("FAIL clr_busy_len: got %0d want 8", busy_cycles); end
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1; rd_a_addr = 3'(i); rd_b_addr = 3'(7 - i);
         tick();
         total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL clr_after_r%0d: got %h want 0000", i, bus_def.rd_a_data); end
         total++; if (bus_rf.rd_b_data !== 16'h0000) begin bad++; $display("FAIL clr_after_rf_r%0d: got %h want 0000", 7 - i, bus_rf.rd_b_data); end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_wr_with_clr();
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555; clr_req = 1'b1;
      tick();
      wr_en = 1'b0; clr_req = 1'b0;
      total++; if (bus_def.clr_busy !== 1'b1) begin bad++; $display("FAIL wc_busy: got %b want 1", bus_def.clr_busy); end
      rd_en = 1'b1; rd_a_addr = 3'd5; rd_b_addr = 3'd5;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h5555) begin bad++; $display("FAIL wc_write_taken: got %h want 5555", bus_def.rd_a_data); end
      total++; if (bus_rf.rd_b_data !== 16'h5555) begin bad++; $display("FAIL wc_write_taken_rf: got %h want 5555", bus_rf.rd_b_data); end
      clr_req = 1'b1;
      repeat (7) tick();
      total++; if (bus_def.clr_done !== 1'b1) begin bad++; $display("FAIL wc_done: got %b want 1", bus_def.clr_done); end
      tick();
      total++; if (bus_def.clr_busy !== 1'b0) begin bad++; $display("FAIL wc_no_requeue: got %b want 0", bus_def.clr_busy); end
      clr_req = 1'b0;
      rd_en = 1'b1; rd_a_addr = 3'd5;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL wc_cleared: got %h want 0000", bus_def.rd_a_data); end
      total++; if (bus_def.clr_busy !== 1'b0) begin bad++; $display("FAIL wc_idle: got %b want 0", bus_def.clr_busy); end
   endtask

   task automatic test_reset_mid_clear();
      logic seen_done;
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0707;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1; rd_a_addr = 3'd7; rd_b_addr = 3'd7;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h0707) begin bad++; $display("FAIL mr_preload: got %h want 0707", bus_def.rd_a_data); end
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      tick();
      total++; if (bus_def.clr_busy !== 1'b1) begin bad++; $display("FAIL mr_busy_before: got %b want 1", bus_def.clr_busy); end
      #2 reset = 1'b0;
      #1;
      total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL mr_async_a: got %h want 0000", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'h0000) begin bad++; $display("FAIL mr_async_b: got %h want 0000", bus_def.rd_b_data); end
      total++; if (bus_def.clr_busy !== 1'b0) begin bad++; $display("FAIL mr_async_busy: got %b want 0", bus_def.clr_busy); end
      tick();
      tick();
      reset = 1'b1;
      seen_done = 1'b0;
      repeat (10) begin
         tick();
         if (bus_def.clr_done === 1'b1) seen_done = 1'b1;
      end
      total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL mr_no_done: got %b want 0", seen_done); end
      rd_en = 1'b1; rd_a_addr = 3'd7; rd_b_addr = 3'd7;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL mr_array_zero: got %h want 0000", bus_def.rd_a_data); end
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0A0A;
      tick();
      wr_addr = 3'd1; wr_data = 16'h0B0B;
      tick();
      wr_en = 1'b0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      total++; if (bus_def.clr_busy !== 1'b1) begin bad++; $display("FAIL mr_restart_busy: got %b want 1", bus_def.clr_busy); end
      tick();
      rd_en = 1'b1; rd_a_addr = 3'd0; rd_b_addr = 3'd1;
      tick();
      rd_en = 1'b0;
      total++; if (bus_def.rd_a_data !== 16'h0000) begin bad++; $display("FAIL mr_idx0_first: got %h want 0000", bus_def.rd_a_data); end
      total++; if (bus_def.rd_b_data !== 16'h0B0B) begin bad++; $display("FAIL mr_idx1_pending: got %h want 0b0b", bus_def.rd_b_data); end
      repeat (6) tick();
      total++; if (bus_def.clr_done !== 1'b1) begin bad++; $display("FAIL mr_restart_done: got %b want 1", bus_def.clr_done); end
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_oor();
      test_hold();
      test_clear();
      test_wr_with_clr();
      test_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/banco_registro_param.md
Name: banco_registro_param

Overview:
Parametrised successor to the processor register bank. It holds NUM_REGS words of DATA_W bits, with one write port and two independent read ports. Read outputs are registered, and a configurable write-to-read bypass is provided. An optional hardwired-zero register 0 is available. A sequenced soft-clear engine wipes the array one word per cycle without asserting reset. It sits between the decode stage (register addresses) and the ALU operand latches.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 3, register address width
NUM_REGS, 8, number of implemented registers; must be ≤ 2**ADDR_W and ≥ 2
ZERO_R0, 0, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read output

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
wr_en  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  1  read enable; when high, both read outputs update
rd_a_addr  input  ADDR_W  read port A address
rd_b_addr  input  ADDR_W  read port B address
rd_a_data  output  DATA_W  registered read data, port A
rd_b_data  output  DATA_W  registered read data, port B
clr_req  input  1  soft-clear request, sampled when the engine is idle
clr_busy  output  1  high while a soft clear is in progress
clr_done  output  1  one-cycle pulse when a soft clear completes

Behaviour:
- Reset (reset=0, asynchronous):
  - all array words = 0
  - rd_a_data = rd_b_data = 0
  - FSM = IDLE; clr_busy = 0; clr_done = 0
- Reset release: synchronous to clock; first active edge is the first edge with reset=1.
- Write: on a rising edge with wr_en=1, FSM=IDLE and wr_addr < NUM_REGS, array[wr_addr] <= wr_data.
  - Ignored if ZERO_R0=1 and wr_addr=0.
  - Ignored if wr_addr ≥ NUM_REGS.
- Read: on a rising edge with rd_en=1, each port captures the word at its address.
  - Latency: 1 cycle from address to data.
  - rd_en=0: outputs hold.
  - Address ≥ NUM_REGS returns 0.
  - ZERO_R0=1 and address 0 returns 0.
  - A and B are fully independent; same address on both ports is legal and returns the same word.
- Bypass:
  - BYPASS=1: a read with the same address as an accepted write on the same edge returns wr_data (write-first).
  - BYPASS=0: the same read returns the old array contents (read-first).
  - Bypass never overrides the ZERO_R0 or out-of-range rules.
- Soft-clear FSM:
  - IDLE: clr_req=1 → CLEAR, with index ← 0. clr_busy rises on the same edge.
  - CLEAR: each edge writes array[index] <= 0 and increments index.
    - Stay in CLEAR while index < NUM_REGS-1.
    - The edge that writes index NUM_REGS-1 moves to DONE.
    - The clear occupies exactly NUM_REGS cycles.
  - DONE: clr_done=1 and clr_busy=0 for this one cycle. Next edge → IDLE unconditionally.
  - clr_req is ignored outside IDLE; requests are not queued.
- During CLEAR or DONE:
  - All external writes are dropped.
  - Reads remain legal and return the current array contents. Words already cleared read 0; words not yet cleared read their old value. Bypass is inactive because no write is accepted.
- Reset asserted mid-clear: FSM → IDLE immediately; array zeroed by reset; no clr_done pulse.
- Simultaneous wr_en and clr_req in IDLE: the write is accepted on that edge. The clear starts on the same edge and its first cycle clears index 0 on the next edge, so the written value is eventually cleared.
- Outputs are driven only from flops. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then write 0x1234→r3 and 0xBEEF→r5. Read A=r3, B=r5 with rd_en=1 → one edge later rd_a_data=0x1234, rd_b_data=0xBEEF.
2. BYPASS=1: in the same cycle wr_en=1, wr_addr=2, wr_data=0xA5A5, rd_a_addr=2 → rd_a_data=0xA5A5 next edge. Repeat with BYPASS=0 → old r2 value, then 0xA5A5 on the following read.
3. ZERO_R0=1: write 0xFFFF→r0, read r0 → 0x0000. Out-of-range read with NUM_REGS=6 and addr 7 → 0x0000; a write to addr 7 leaves r0–r5 unchanged.
4. Fill r0–r7 with 0x0011·(i+1), then pulse clr_req:
   - clr_busy high for 8 cycles, then clr_done high for 1 cycle.
   - A mid-clear write to r7 is dropped.
   - Reads during the clear show r0–r3 = 0 while r7 still = 0x0088 at cycle 4; all registers = 0 after clr_done.
5. Assert reset=0 at cycle 3 of a clear → outputs 0 asynchronously, clr_busy=0, no clr_done. After release, a new clr_req restarts from index 0.
6. rd_en=0 with changing addresses and writes → rd_a_data and rd_b_data hold their last values.
